// File: rtl/mem_arb2.sv
// mem_arb2 -- two-port round-robin arbiter in front of the single-port
// fabric memory handshake (req_rd/req_wr pulse, data_rdy low then high).
// Each requester holds a level rd/wr request and gets a one-cycle ack,
// with read data for reads. All outputs are registered.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to bound a hung memory
// cycle at TIMEOUT_CYC cycles; otherwise rq_err is tied low.

module mem_arb2 #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [1:0]  rq_rd,
    input  logic [1:0]  rq_wr,
    input  logic [31:0] rq_addr0,
    input  logic [31:0] rq_addr1,
    input  logic [31:0] rq_wdata0,
    input  logic [31:0] rq_wdata1,
    output logic [1:0]  rq_ack,
    output logic [31:0] rq_rdata,
    output logic        rq_err,
    output logic        mem_req_rd,
    output logic        mem_req_wr,
    output logic [31:0] mem_addr_rd,
    output logic [31:0] mem_addr_wr,
    output logic [31:0] mem_data_wr,
    input  logic [31:0] mem_data_rd,
    input  logic        mem_data_rdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        winner_q, winner_d;        // requester owning the current transaction
    logic        op_wr_q, op_wr_d;          // 1 = write, 0 = read
    logic        last_grant_q, last_grant_d;
    logic [1:0]  ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_rd_q, req_rd_d;
    logic        req_wr_q, req_wr_d;
    logic [31:0] addr_rd_q, addr_rd_d;
    logic [31:0] addr_wr_q, addr_wr_d;
    logic [31:0] wdata_q, wdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wdog_q, wdog_d;             // cycles elapsed since the ISSUE cycle
    logic       err_q, err_d;
`else
    // Keeps the parameter referenced when the watchdog is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    // Requester selection: a lone requester wins; on a tie the one not served last wins.
    logic [1:0]  pending;
    logic        pick;
    logic        pick_rd;
    logic [31:0] pick_addr;
    logic [31:0] pick_wdata;

    assign pending    = rq_rd | rq_wr;
    assign pick       = (pending == 2'b11) ? ~last_grant_q : pending[1];
    assign pick_rd    = rq_rd[pick];        // read has priority when rd and wr are both held
    assign pick_addr  = pick ? rq_addr1  : rq_addr0;
    assign pick_wdata = pick ? rq_wdata1 : rq_wdata0;

    // Next-state and registered-output logic for the handshake sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        winner_d     = winner_q;
        op_wr_d      = op_wr_q;
        last_grant_d = last_grant_q;
        ack_d        = 2'b00;
        rdata_d      = rdata_q;
        req_rd_d     = 1'b0;
        req_wr_d     = 1'b0;
        addr_rd_d    = addr_rd_q;
        addr_wr_d    = addr_wr_q;
        wdata_d      = wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        wdog_d       = wdog_q;
        err_d        = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // Only issue onto an idle memory; this also absorbs a cycle abandoned by reset.
                if (mem_data_rdy && (pending != 2'b00)) begin
                    winner_d = pick;
                    op_wr_d  = ~pick_rd;
                    if (pick_rd) begin
                        req_rd_d  = 1'b1;
                        addr_rd_d = pick_addr;
                    end else begin
                        req_wr_d  = 1'b1;
                        addr_wr_d = pick_addr;
                        wdata_d   = pick_wdata;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    wdog_d = 8'd0;
`endif
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                state_d = S_WAIT_LO;
            end

            S_WAIT_LO: begin
                if (!mem_data_rdy) begin
                    state_d = S_WAIT_HI;
                end
            end

            S_WAIT_HI: begin
                if (mem_data_rdy) begin
                    if (!op_wr_q) begin
                        rdata_d = mem_data_rd;
                    end
                    last_grant_d = winner_q;
                    ack_d        = winner_q ? 2'b10 : 2'b01;
                    state_d      = S_DONE;
                end
            end

            S_DONE: begin
                // Requests are deliberately not sampled here.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: a normal completion in the same cycle takes precedence.
        if (state_q == S_ISSUE || state_q == S_WAIT_LO || state_q == S_WAIT_HI) begin
            wdog_d = wdog_q + 8'd1;
        end
        if ((state_q == S_WAIT_LO || state_q == S_WAIT_HI) &&
            (state_d != S_DONE) && (wdog_q == TO_LAST)) begin
            rdata_d      = 32'd0;
            last_grant_d = winner_q;
            ack_d        = winner_q ? 2'b10 : 2'b01;
            err_d        = 1'b1;
            state_d      = S_DONE;
        end
`endif
    end

    // State and output registers; reset abandons any in-flight memory cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_IDLE;
            winner_q     <= 1'b0;
            op_wr_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ack_q        <= 2'b00;
            rdata_q      <= 32'd0;
            req_rd_q     <= 1'b0;
            req_wr_q     <= 1'b0;
            addr_rd_q    <= 32'd0;
            addr_wr_q    <= 32'd0;
            wdata_q      <= 32'd0;
`ifdef MEM_ARB_TIMEOUT_EN
            wdog_q       <= 8'd0;
            err_q        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q      <= state_d;
            winner_q     <= winner_d;
            op_wr_q      <= op_wr_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            req_rd_q     <= req_rd_d;
            req_wr_q     <= req_wr_d;
            addr_rd_q    <= addr_rd_d;
            addr_wr_q    <= addr_wr_d;
            wdata_q      <= wdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wdog_q       <= wdog_d;
            err_q        <= err_d;
`endif
        end
    end

    assign rq_ack      = ack_q;
    assign rq_rdata    = rdata_q;
    assign mem_req_rd  = req_rd_q;
    assign mem_req_wr  = req_wr_q;
    assign mem_addr_rd = addr_rd_q;
    assign mem_addr_wr = addr_wr_q;
    assign mem_data_wr = wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign rq_err      = err_q;
`else
    assign rq_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2 with a small registered memory model:
// a request pulse drops data_rdy next edge, and the following edge
// (unless held) raises it again and completes the access.

module tb_mem_arb2;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        arst;
    logic [1:0]  rq_rd, rq_wr;
    logic [31:0] rq_addr0, rq_addr1, rq_wdata0, rq_wdata1;
    logic [1:0]  rq_ack;
    logic [31:0] rq_rdata;
    logic        rq_err;
    logic        mem_req_rd, mem_req_wr;
    logic [31:0] mem_addr_rd, mem_addr_wr, mem_data_wr;
    logic [31:0] mem_data_rd;
    logic        mem_data_rdy;

    // Memory model state
    logic [31:0] mem [4096];
    logic        m_init, m_hold, m_busy, m_wr;
    logic [31:0] m_addr, m_wdata;
    logic        pl_en;
    logic [11:0] pl_idx;
    logic [31:0] pl_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_arb2 #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .arst         (arst),
        .rq_rd        (rq_rd),
        .rq_wr        (rq_wr),
        .rq_addr0     (rq_addr0),
        .rq_addr1     (rq_addr1),
        .rq_wdata0    (rq_wdata0),
        .rq_wdata1    (rq_wdata1),
        .rq_ack       (rq_ack),
        .rq_rdata     (rq_rdata),
        .rq_err       (rq_err),
        .mem_req_rd   (mem_req_rd),
        .mem_req_wr   (mem_req_wr),
        .mem_addr_rd  (mem_addr_rd),
        .mem_addr_wr  (mem_addr_wr),
        .mem_data_wr  (mem_data_wr),
        .mem_data_rd  (mem_data_rd),
        .mem_data_rdy (mem_data_rdy)
    );

    // Memory: one busy cycle per access, stretched while m_hold is set.
    always @(posedge clk) begin
        if (m_init) begin
            mem_data_rdy <= 1'b1;
            mem_data_rd  <= 32'd0;
            m_busy       <= 1'b0;
            m_wr         <= 1'b0;
            m_addr       <= 32'd0;
            m_wdata      <= 32'd0;
        end else if (mem_req_rd || mem_req_wr) begin
            mem_data_rdy <= 1'b0;
            m_busy       <= 1'b1;
            m_wr         <= mem_req_wr;
            m_addr       <= mem_req_wr ? mem_addr_wr : mem_addr_rd;
            m_wdata      <= mem_data_wr;
        end else if (m_busy && !m_hold) begin
            mem_data_rdy <= 1'b1;
            m_busy       <= 1'b0;
            if (m_wr) mem[m_addr[13:2]] <= m_wdata;
            else      mem_data_rd <= mem[m_addr[13:2]];
        end
        if (pl_en) mem[pl_idx] <= pl_data;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] idx, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        tick();
        pl_en   = 1'b0;
    endtask

    // Advance until a memory request pulse is visible (bounded).
    task automatic wait_req(input string tag);
        int c = 0;
        do begin tick(); c++; end while (!(mem_req_rd || mem_req_wr) && c < 40);
        check({tag, "_req_seen"}, 32'(mem_req_rd | mem_req_wr), 32'd1);
    endtask

    // Advance until an ack is visible (bounded); returns cycles taken.
    task automatic wait_ack(input string tag, output int c);
        c = 0;
        do begin tick(); c++; end while (rq_ack == 2'b00 && c < 60);
        check({tag, "_ack_seen"}, 32'(rq_ack != 2'b00), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected finished");
        $fatal(1);
    end

    initial begin
        int n_req, n_ack, c;
        logic [1:0]  ack_log [4];
        logic [31:0] rd_log  [4];
        int          ack_k   [4];

        arst = 1'b1; m_init = 1'b1; m_hold = 1'b0; pl_en = 1'b0;
        pl_idx = '0; pl_data = '0;
        rq_rd = 2'b00; rq_wr = 2'b00;
        rq_addr0 = '0; rq_addr1 = '0; rq_wdata0 = '0; rq_wdata1 = '0;
        tick();
        preload(12'd2,  32'hDEADBEEF);
        preload(12'd4,  32'hA0A00001);
        preload(12'd8,  32'hB0B00002);
        preload(12'd12, 32'hC0FFEE00);
        preload(12'd16, 32'h0BADF00D);

        // Reset state
        check("rst_ack",     32'(rq_ack),     32'd0);
        check("rst_rdata",   rq_rdata,        32'd0);
        check("rst_err",     32'(rq_err),     32'd0);
        check("rst_req_rd",  32'(mem_req_rd), 32'd0);
        check("rst_req_wr",  32'(mem_req_wr), 32'd0);
        check("rst_addr_rd", mem_addr_rd,     32'd0);
        check("rst_addr_wr", mem_addr_wr,     32'd0);
        check("rst_data_wr", mem_data_wr,     32'd0);
        arst = 1'b0; m_init = 1'b0;
        tick();

        // Single read from requester 0
        rq_addr0 = 32'h40000008; rq_rd = 2'b01;
        tick();
        check("t1_req_rd",  32'(mem_req_rd), 32'd1);
        check("t1_req_wr",  32'(mem_req_wr), 32'd0);
        check("t1_addr_rd", mem_addr_rd,     32'h40000008);
        tick();
        check("t1_req_pulse", 32'(mem_req_rd), 32'd0);
        tick();
        check("t1_ack_early", 32'(rq_ack), 32'd0);
        tick();
        check("t1_ack",   32'(rq_ack), 32'd1);
        check("t1_rdata", rq_rdata,    32'hDEADBEEF);
        check("t1_err",   32'(rq_err), 32'd0);
        rq_rd = 2'b00;
        tick();
        check("t1_ack_once",  32'(rq_ack), 32'd0);
        check("t1_rdata_hold", rq_rdata,   32'hDEADBEEF);

        // Single write from requester 1
        rq_addr1 = 32'h40002004; rq_wdata1 = 32'h12345678; rq_wr = 2'b10;
        tick();
        check("t2_req_wr",   32'(mem_req_wr), 32'd1);
        check("t2_req_rd",   32'(mem_req_rd), 32'd0);
        check("t2_addr_wr",  mem_addr_wr,     32'h40002004);
        check("t2_data_wr",  mem_data_wr,     32'h12345678);
        check("t2_addr_rd_held", mem_addr_rd, 32'h40000008);
        tick(); tick(); tick();
        check("t2_ack",   32'(rq_ack), 32'd2);
        check("t2_err",   32'(rq_err), 32'd0);
        check("t2_rdata_hold", rq_rdata, 32'hDEADBEEF);
        rq_wr = 2'b00;
        tick();
        check("t2_mem_written", mem[12'h801], 32'h12345678);

        // Contention: both requesters read continuously; last grant was 1
        rq_addr0 = 32'h40000010; rq_addr1 = 32'h40000020; rq_rd = 2'b11;
        n_req = 0; n_ack = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mem_req_rd || mem_req_wr) n_req++;
            if (rq_ack != 2'b00) begin
                if (n_ack < 4) begin
                    ack_log[n_ack] = rq_ack;
                    rd_log[n_ack]  = rq_rdata;
                    ack_k[n_ack]   = k;
                end
                n_ack++;
            end
        end
        rq_rd = 2'b00;
        check("t3_req_count", 32'(n_req), 32'd4);
        check("t3_ack_count", 32'(n_ack), 32'd4);
        if (n_ack >= 4) begin
            check("t3_ack0", 32'(ack_log[0]), 32'd1);
            check("t3_ack1", 32'(ack_log[1]), 32'd2);
            check("t3_ack2", 32'(ack_log[2]), 32'd1);
            check("t3_ack3", 32'(ack_log[3]), 32'd2);
            check("t3_rd0",  rd_log[0], 32'hA0A00001);
            check("t3_rd1",  rd_log[1], 32'hB0B00002);
            check("t3_k0",   32'(ack_k[0]), 32'd3);
            check("t3_k3",   32'(ack_k[3]), 32'd18);
        end
        tick();

        // Requester 0 holds rd and wr together: read first, then write
        rq_addr0 = 32'h40000030; rq_wdata0 = 32'h55AA55AA;
        rq_rd = 2'b01; rq_wr = 2'b01;
        tick();
        check("t4_req_rd",  32'(mem_req_rd), 32'd1);
        check("t4_req_wr0", 32'(mem_req_wr), 32'd0);
        tick(); tick(); tick();
        check("t4_ack_rd", 32'(rq_ack), 32'd1);
        check("t4_rdata",  rq_rdata,    32'hC0FFEE00);
        rq_rd = 2'b00;
        tick(); tick();
        check("t4_req_wr",  32'(mem_req_wr), 32'd1);
        check("t4_addr_wr", mem_addr_wr,     32'h40000030);
        check("t4_data_wr", mem_data_wr,     32'h55AA55AA);
        tick(); tick(); tick();
        check("t4_ack_wr",  32'(rq_ack), 32'd1);
        check("t4_rdata_hold", rq_rdata, 32'hC0FFEE00);
        rq_wr = 2'b00;
        tick();
        check("t4_mem_written", mem[12'd12], 32'h55AA55AA);

        // Reset during WAIT_LO with the memory stuck busy
        m_hold = 1'b1;
        rq_addr1 = 32'h40000040; rq_rd = 2'b10;
        tick();
        check("t5_req_rd", 32'(mem_req_rd), 32'd1);
        tick();
        arst = 1'b1;
        #1;
        check("t5_rst_ack",     32'(rq_ack),     32'd0);
        check("t5_rst_req_rd",  32'(mem_req_rd), 32'd0);
        check("t5_rst_addr_rd", mem_addr_rd,     32'd0);
        check("t5_rst_addr_wr", mem_addr_wr,     32'd0);
        check("t5_rst_data_wr", mem_data_wr,     32'd0);
        check("t5_rst_rdata",   rq_rdata,        32'd0);
        tick();
        rq_addr0 = 32'h40000010; rq_rd = 2'b11;
        arst = 1'b0;
        n_req = 0; n_ack = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mem_req_rd || mem_req_wr) n_req++;
            if (rq_ack != 2'b00) n_ack++;
        end
        check("t5_no_issue_busy", 32'(n_req), 32'd0);
        check("t5_no_ack_busy",   32'(n_ack), 32'd0);
        m_hold = 1'b0;
        wait_req("t5");
        check("t5_tie_addr", mem_addr_rd, 32'h40000010);
        wait_ack("t5a", c);
        check("t5_ack0",  32'(rq_ack), 32'd1);
        check("t5_rd0",   rq_rdata,    32'hA0A00001);
        rq_rd = 2'b10;
        wait_ack("t5b", c);
        check("t5_ack1",  32'(rq_ack), 32'd2);
        check("t5_rd1",   rq_rdata,    32'h0BADF00D);
        rq_rd = 2'b00;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: memory never returns ready
        m_hold = 1'b1;
        rq_addr0 = 32'h40000010; rq_rd = 2'b01;
        wait_req("t6");
        wait_ack("t6", c);
        check("t6_latency", 32'(c),      32'(TO));
        check("t6_ack",     32'(rq_ack), 32'd1);
        check("t6_err",     32'(rq_err), 32'd1);
        check("t6_rdata",   rq_rdata,    32'd0);
        rq_rd = 2'b00;
        tick();
        check("t6_ack_clr", 32'(rq_ack), 32'd0);
        check("t6_err_clr", 32'(rq_err), 32'd0);
        m_hold = 1'b0;
        rq_addr1 = 32'h40000020; rq_rd = 2'b10;
        wait_ack("t6b", c);
        check("t6_after_ack",   32'(rq_ack), 32'd2);
        check("t6_after_rdata", rq_rdata,    32'hB0B00002);
        rq_rd = 2'b00;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arb2.md
# mem_arb2

Two-port round-robin arbiter that shares the single-port fabric memory interface (req_rd/req_wr, addr/data, data_rdy handshake) between two requesters, e.g. the fabric32 load and store engines. Each requester presents a level request and receives a one-cycle acknowledge with read data. The block sequences the memory handshake itself and optionally bounds a hung transaction with a watchdog.

## Interface
- TIMEOUT_CYC, 255: watchdog limit in cycles spent in WAIT_LO+WAIT_HI (used only with MEM_ARB_TIMEOUT_EN); 8-bit counter.
- clk  in  1  clock, all logic on rising edge.
- arst  in  1  reset; asynchronous, active-high.
- rq_rd  in  2  per-requester read request, level, held until its rq_ack.
- rq_wr  in  2  per-requester write request, level, held until its rq_ack.
- rq_addr0, rq_addr1  in  32  byte address per requester, stable while requesting.
- rq_wdata0, rq_wdata1  in  32  write data per requester.
- rq_ack  out  2  one-cycle completion pulse, one-hot.
- rq_rdata  out  32  read data, valid in the rq_ack cycle of a read; holds otherwise.
- rq_err  out  1  pulses with rq_ack when the transaction timed out.
- mem_req_rd, mem_req_wr  out  1  memory requests, one-cycle pulses, never both.
- mem_addr_rd, mem_addr_wr  out  32  memory addresses, held from ISSUE to DONE.
- mem_data_wr  out  32  memory write data.
- mem_data_rd  in  32  memory read data.
- mem_data_rdy  in  1  memory idle/complete flag; only value 1 counts as ready.

## Operation
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE. All outputs registered.
- IDLE: if mem_data_rdy==1 and any requester pending (rd|wr), pick winner, latch op/address/wdata, go ISSUE. Otherwise stay.
- Winner: if one requester pending, it wins. If both, the one not granted last wins; last_grant resets to 1 so requester 0 wins the first tie.
- Op: if a requester asserts rd and wr together, read is served; write stays pending for a later grant.
- ISSUE: mem_req_rd or mem_req_wr = 1 for exactly this cycle; address on the matching mem_addr bus, the other bus unchanged. Go WAIT_LO.
- WAIT_LO: wait for mem_data_rdy==0 (memory accepted). Go WAIT_HI.
- WAIT_HI: wait for mem_data_rdy==1; on it, capture mem_data_rd (reads only) into rq_rdata, set last_grant=winner, go DONE.
- DONE: rq_ack[winner]=1 for this cycle only; go IDLE. Requests are not sampled in DONE, so a requester that drops on ack is never double-served.
- Reset (any time, including mid-transaction): state IDLE, rq_ack=0, rq_err=0, rq_rdata=0, mem_req_*=0, mem_addr_*=0, mem_data_wr=0, last_grant=1, watchdog=0. An in-flight memory cycle is abandoned; the IDLE rule (wait for mem_data_rdy==1) keeps the next issue clean.

## Timing
- Request seen in IDLE at edge N (memory ready): mem_req_* high in cycle N+1, mem_data_rdy low N+2, high N+3, rq_ack in cycle N+4 → 4-cycle latency, 5-cycle occupancy including the return to IDLE.
- Back-to-back, both requesters pending: grants alternate 0,1,0,1; one transaction per 5 cycles.
- Requester deasserting before ack: undefined; the latched transaction still completes and acks.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: 8-bit counter cleared on ISSUE, increments each cycle in WAIT_LO/WAIT_HI; on reaching TIMEOUT_CYC go DONE with rq_err=1 alongside rq_ack, rq_rdata=0, last_grant updated.
- Not defined: no counter; WAIT_LO/WAIT_HI wait indefinitely; rq_err tied 0.

## Test plan
- Single read: rq_rd=2'b01, rq_addr0=0x40000008, mem holds 0xDEADBEEF at word 2 → mem_req_rd one cycle with mem_addr_rd=0x40000008; rq_ack=2'b01 4 cycles after sampling; rq_rdata=0xDEADBEEF.
- Single write: rq_wr=2'b10, rq_addr1=0x40002004, rq_wdata1=0x12345678 → mem_req_wr one pulse, mem_addr_wr=0x40002004, mem_data_wr=0x12345678; rq_ack=2'b10; rq_err=0.
- Contention: both rq_rd asserted continuously from reset, re-asserted after each ack → ack order 0,1,0,1; exactly one mem_req pulse per 5 cycles.
- Both rd and wr from requester 0 → read acked first; write issued on the next grant.
- Reset mid-op: arst pulse during WAIT_LO → all outputs 0 next cycle, no ack; after release, pending request issues only once mem_data_rdy==1 and completes normally.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, memory holding mem_data_rdy=0 → rq_ack and rq_err pulse together 16 cycles after ISSUE, rq_rdata=0, arbiter back in IDLE.
